// File: rtl/nfc_cmd_arbiter.sv
// nfc_cmd_arbiter: two-requester round-robin front end for the NAND flash controller
// host command port. It grants one requester, issues start/cmd/address, waits for
// completion and returns done/err to the owner.
// Optional WAIT-state watchdog: define NFC_ARB_TIMEOUT_EN.
module nfc_cmd_arbiter #(
    parameter int unsigned AddressWidth  = 16,
    parameter int unsigned CommandWidth  = 3,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [CommandWidth-1:0] cmd0,
    input  logic [CommandWidth-1:0] cmd1,
    input  logic [AddressWidth-1:0] addr0,
    input  logic [AddressWidth-1:0] addr1,
    output logic                    ack0,
    output logic                    ack1,
    output logic                    done0,
    output logic                    done1,
    output logic                    err0,
    output logic                    err1,
    output logic                    nfc_start,
    output logic [CommandWidth-1:0] nfc_cmd,
    output logic [AddressWidth-1:0] RWA,
    input  logic                    nfc_done,
    input  logic                    command_error,
    output logic                    busy,
    output logic                    owner,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e state_q;
    logic   prio_q;

    logic grant_c;
    logic wait_exit_c;
    logic wait_err_c;
    logic wd_expire_c;

    // Winner in IDLE: the lone requester, or the priority pointer on a tie.
    assign grant_c = (req0 && req1) ? prio_q : req1;

    // A TimeoutCycles below 2 leaves no WAIT cycle before expiry; this empty
    // guard marks that range as unsupported.
    if (TimeoutCycles < 2) begin : g_unsupported_timeout
    end

`ifdef NFC_ARB_TIMEOUT_EN
    localparam int unsigned CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

    logic [CntWidth-1:0] wd_cnt_q;

    // Watchdog fires when the WAIT counter reaches its last value.
    assign wd_expire_c = (state_q == ST_WAIT) &&
                         (wd_cnt_q == CntWidth'(TimeoutCycles - 1));
`else
    assign wd_expire_c = 1'b0;
`endif

    // nfc_done has priority over a coincident watchdog expiry.
    assign wait_exit_c = nfc_done || wd_expire_c;
    assign wait_err_c  = nfc_done ? command_error : 1'b1;

    // Arbitration FSM with registered controller and requester outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            nfc_start <= 1'b0;
            nfc_cmd   <= '0;
            RWA       <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            timeout   <= 1'b0;
`ifdef NFC_ARB_TIMEOUT_EN
            wd_cnt_q  <= '0;
`endif
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            nfc_start <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_q   <= ST_ISSUE;
                        busy      <= 1'b1;
                        owner     <= grant_c;
                        nfc_cmd   <= grant_c ? cmd1 : cmd0;
                        RWA       <= grant_c ? addr1 : addr0;
                        ack0      <= ~grant_c;
                        ack1      <= grant_c;
                        nfc_start <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q  <= ST_WAIT;
`ifdef NFC_ARB_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
`ifdef NFC_ARB_TIMEOUT_EN
                    wd_cnt_q <= wd_cnt_q + CntWidth'(1);
`endif
                    if (wait_exit_c) begin
                        state_q <= ST_RESP;
                        done0   <= ~owner;
                        done1   <= owner;
                        err0    <= ~owner & wait_err_c;
                        err1    <= owner & wait_err_c;
                        if (wd_expire_c && !nfc_done) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    prio_q  <= ~owner;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
